// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with 3-sample majority voting,
// optional parity check and stop-bit check; registered strobes.
module uart_rx_core #(
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [5:0]       Prescale,
  output logic [Width-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR
);

  localparam int BW = $clog2(Width + 3);
  localparam logic [BW-1:0] LAST = BW'(Width);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, state_nx;

  logic [5:0]       edge_cnt, p_q, mid;
  logic [BW-1:0]    bit_cnt;
  logic             pe_q, pt_q;
  logic             s0, s1, bit_q, bad;
  logic [Width-1:0] shreg;
  logic             at_s0, at_s1, at_v;
  logic             at_pre, at_end;
  logic             vote, par_exp;

  assign mid     = p_q >> 1;
  assign at_s0   = edge_cnt == mid - 6'd1;
  assign at_s1   = edge_cnt == mid;
  assign at_v    = edge_cnt == mid + 6'd1;
  // strobes are registered, so they are set one cycle before the bit ends
  assign at_pre  = edge_cnt == p_q - 6'd2;
  assign at_end  = edge_cnt == p_q - 6'd1;
  assign vote    = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
  assign par_exp = (^shreg) ^ pt_q;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (!RX_IN) state_nx = START;
      START: begin
        if (at_v && vote)  state_nx = IDLE;
        else if (at_end)   state_nx = DATA;
      end
      DATA: begin
        if (at_end && bit_cnt == LAST)
          state_nx = pe_q ? PARITY : STOP;
      end
      PARITY: if (at_end) state_nx = STOP;
      STOP:   if (at_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_q      <= '0;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
    end else if (state == IDLE) begin
      edge_cnt <= {5'd0, ~RX_IN};
      bit_cnt  <= '0;
      if (!RX_IN) begin
        p_q  <= Prescale;
        pe_q <= PAR_EN;
        pt_q <= PAR_TYP;
      end
    end else if (state_nx == IDLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (at_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BW'(1);
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      bit_q      <= 1'b1;
      bad        <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state == IDLE) bad <= 1'b0;
      if (state != IDLE) begin
        if (at_s0) s0    <= RX_IN;
        if (at_s1) s1    <= RX_IN;
        if (at_v)  bit_q <= vote;
      end
      if (state == DATA && at_v)
        shreg <= {vote, shreg[Width-1:1]};
      if (state == PARITY && at_pre && bit_q != par_exp) begin
        PAR_ERR <= 1'b1;
        bad     <= 1'b1;
      end
      if (state == STOP && at_pre) begin
        STP_ERR <= ~bit_q;
        if (bit_q && !bad) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with hand-computed strobe cycles,
// checked with immediate assertions.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [7:0] p_data;
  logic       dv, perr, serr;

  int errors = 0;
  int checks = 0;

  bit         line[$];
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];
  int         pe_cyc[$];
  int         se_cyc[$];
  logic [10:0] snap;
  int         rst_at = -1;

  always #5 clk = ~clk;

  uart_rx_core #(.Width(8)) dut (
    .CLK(clk),
    .RST(rst),
    .RX_IN(rx),
    .PAR_EN(par_en),
    .PAR_TYP(par_typ),
    .Prescale(prescale),
    .P_DATA(p_data),
    .DATA_VALID(dv),
    .PAR_ERR(perr),
    .STP_ERR(serr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nth_i(input int q[$], input int n);
    return (q.size() > n) ? q[n] : -1;
  endfunction

  function automatic logic [7:0] nth_d(input logic [7:0] q[$], input int n);
    return (q.size() > n) ? q[n] : 8'hxx;
  endfunction

  task automatic add_bits(input int n, input bit b);
    repeat (n) line.push_back(b);
  endtask

  task automatic add_frame(input int p, input logic [7:0] d,
                           input bit pe, input bit pb, input bit sb);
    add_bits(p, 1'b0);
    for (int i = 0; i < 8; i++) add_bits(p, d[i]);
    if (pe) add_bits(p, pb);
    add_bits(p, sb);
  endtask

  // one line entry per clock cycle; events logged by cycle index
  task automatic play();
    dv_cyc.delete();
    dv_dat.delete();
    pe_cyc.delete();
    se_cyc.delete();
    snap = '1;
    foreach (line[c]) begin
      rx  = line[c];
      rst = (c == rst_at);
      @(negedge clk);
      if (dv) begin
        dv_cyc.push_back(c);
        dv_dat.push_back(p_data);
      end
      if (perr) pe_cyc.push_back(c);
      if (serr) se_cyc.push_back(c);
      if (c == rst_at + 1) snap = {p_data, dv, perr, serr};
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    rx  = 1'b1;
    line.delete();
    rst_at = -1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {21'd0, p_data, dv, perr, serr}, 32'd0);
    @(posedge clk);
    #1;

    // P=8 even parity, good frame
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    add_frame(8, 8'hA5, 1'b1, 1'b0, 1'b1);
    add_bits(8, 1'b1);
    play();
    chk("t1_dv_count", dv_cyc.size(), 1);
    chk("t1_dv_cycle", nth_i(dv_cyc, 0), 87);
    chk("t1_data", nth_d(dv_dat, 0), 8'hA5);
    chk("t1_err_count", pe_cyc.size() + se_cyc.size(), 0);

    // P=8 odd parity, parity bit wrong
    par_typ = 1'b1;
    add_frame(8, 8'hA5, 1'b1, 1'b0, 1'b1);
    add_bits(8, 1'b1);
    play();
    chk("t2_pe_count", pe_cyc.size(), 1);
    chk("t2_pe_cycle", nth_i(pe_cyc, 0), 79);
    chk("t2_dv_count", dv_cyc.size(), 0);
    chk("t2_se_count", se_cyc.size(), 0);
    chk("t2_pdata_hold", p_data, 8'hA5);

    // P=16 no parity, stop error then good frame
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    add_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0);
    add_bits(16, 1'b1);
    play();
    chk("t3_se_count", se_cyc.size(), 1);
    chk("t3_se_cycle", nth_i(se_cyc, 0), 159);
    chk("t3_dv_count", dv_cyc.size(), 0);
    chk("t3_pdata_hold", p_data, 8'hA5);
    add_frame(16, 8'h81, 1'b0, 1'b0, 1'b1);
    add_bits(16, 1'b1);
    play();
    chk("t3b_dv_cycle", nth_i(dv_cyc, 0), 159);
    chk("t3b_data", nth_d(dv_dat, 0), 8'h81);

    // P=16 three-cycle glitch, then a 0x55 frame at cycle 20
    add_bits(3, 1'b0);
    add_bits(17, 1'b1);
    add_frame(16, 8'h55, 1'b0, 1'b0, 1'b1);
    add_bits(16, 1'b1);
    play();
    chk("t4_dv_count", dv_cyc.size(), 1);
    chk("t4_dv_cycle", nth_i(dv_cyc, 0), 179);
    chk("t4_data", nth_d(dv_dat, 0), 8'h55);
    chk("t4_err_count", pe_cyc.size() + se_cyc.size(), 0);

    // P=32 back-to-back frames
    prescale = 6'd32;
    add_frame(32, 8'h01, 1'b0, 1'b0, 1'b1);
    add_frame(32, 8'hFE, 1'b0, 1'b0, 1'b1);
    add_bits(32, 1'b1);
    play();
    chk("t5_dv_count", dv_cyc.size(), 2);
    chk("t5_dv0_cycle", nth_i(dv_cyc, 0), 319);
    chk("t5_dv1_cycle", nth_i(dv_cyc, 1), 639);
    chk("t5_data0", nth_d(dv_dat, 0), 8'h01);
    chk("t5_data1", nth_d(dv_dat, 1), 8'hFE);

    // P=8 reset at frame cycle 40, then 0x5A frame at cycle 101
    prescale = 6'd8;
    add_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1);
    line = line[0:40];
    add_bits(60, 1'b1);
    add_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1);
    add_bits(8, 1'b1);
    rst_at = 40;
    play();
    chk("t6_after_reset", {21'd0, snap}, 32'd0);
    chk("t6_dv_count", dv_cyc.size(), 1);
    chk("t6_dv_cycle", nth_i(dv_cyc, 0), 180);
    chk("t6_data", nth_d(dv_dat, 0), 8'h5A);
    chk("t6_err_count", pe_cyc.size() + se_cyc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
